// File: rtl/cpu_private_reg_initiator.sv
// Single-outstanding register-bus initiator: command handshake in, one reg_req/reg_rsp
// transaction out, result handshake back, with a bus-hang timeout.

package cpu_private_reg_pkg;
  localparam int unsigned REG_AW = 32;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0]   addr;
    logic                write;
    logic [REG_DW-1:0]   wdata;
    logic [REG_DW/8-1:0] wstrb;
    logic                valid;
  } reg_req_t;

  typedef struct packed {
    logic [REG_DW-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;
endpackage

module cpu_private_reg_initiator #(
  parameter type         reg_req_t = cpu_private_reg_pkg::reg_req_t,
  parameter type         reg_rsp_t = cpu_private_reg_pkg::reg_rsp_t,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_write_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_wstrb_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [DW-1:0]   res_rdata_o,
  output logic            res_error_o,
  output logic            res_timeout_o,
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            error_q, error_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_inc;
  logic            timeout_hit;

  // Next-state and datapath; ready wins over a timeout landing in the same cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    timeout_d   = timeout_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_write_i ? cmd_wdata_i : '0;
          wstrb_d = cmd_write_i ? cmd_wstrb_i : '0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (reg_rsp_i.ready) begin
          rdata_d   = write_q ? '0 : DW'(reg_rsp_i.rdata);
          error_d   = reg_rsp_i.error;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
          // Abandon a hung responder: valid drops without ever seeing ready.
          if (timeout_hit) begin
            rdata_d   = '0;
            error_d   = 1'b1;
            timeout_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus request is built purely from flops, so reg_rsp_i never reaches reg_req_o.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q == REQ);
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign res_valid_o   = (state_q == RESP);
  assign res_rdata_o   = rdata_q;
  assign res_error_o   = error_q;
  assign res_timeout_o = timeout_q;

endmodule

// File: tb/tb_cpu_private_reg_initiator.sv
// Bench for cpu_private_reg_initiator: directed transactions on two instances
// (long and short timeout) with a result scoreboard popped by a monitor.

module tb_cpu_private_reg_initiator;
  import cpu_private_reg_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } res_t;

  logic        clk, rst_n, sel;
  logic        cmd_valid, cmd_write, res_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  reg_rsp_t    rsp;

  logic        cmd_valid_a, cmd_ready_a, res_valid_a, res_error_a, res_timeout_a;
  logic        cmd_valid_b, cmd_ready_b, res_valid_b, res_error_b, res_timeout_b;
  logic [31:0] res_rdata_a, res_rdata_b;
  reg_req_t    req_a, req_b;
  reg_rsp_t    rsp_a, rsp_b;

  logic        cmd_ready, res_valid, res_error, res_timeout;
  logic [31:0] res_rdata;
  reg_req_t    req;

  res_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // sel=0 drives/observes the TIMEOUT=16 instance, sel=1 the TIMEOUT=4 instance.
  assign cmd_valid_a = cmd_valid & ~sel;
  assign cmd_valid_b = cmd_valid & sel;
  assign rsp_a       = sel ? '0 : rsp;
  assign rsp_b       = sel ? rsp : '0;
  assign cmd_ready   = sel ? cmd_ready_b   : cmd_ready_a;
  assign res_valid   = sel ? res_valid_b   : res_valid_a;
  assign res_rdata   = sel ? res_rdata_b   : res_rdata_a;
  assign res_error   = sel ? res_error_b   : res_error_a;
  assign res_timeout = sel ? res_timeout_b : res_timeout_a;
  assign req         = sel ? req_b         : req_a;

  cpu_private_reg_initiator #(
    .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t), .AW(32), .DW(32), .TIMEOUT(16)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .res_valid_o(res_valid_a), .res_ready_i(res_ready), .res_rdata_o(res_rdata_a),
    .res_error_o(res_error_a), .res_timeout_o(res_timeout_a),
    .reg_req_o(req_a), .reg_rsp_i(rsp_a)
  );

  cpu_private_reg_initiator #(
    .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t), .AW(32), .DW(32), .TIMEOUT(4)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .res_valid_o(res_valid_b), .res_ready_i(res_ready), .res_rdata_o(res_rdata_b),
    .res_error_o(res_error_b), .res_timeout_o(res_timeout_b),
    .reg_req_o(req_b), .reg_rsp_i(rsp_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one command; returns one cycle later (first REQ cycle).
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic push,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_to);
    res_t e;
    chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    if (push) begin
      e.rdata = e_rdata;
      e.err   = e_err;
      e.to    = e_to;
      exp_q.push_back(e);
    end
    tick();
    cmd_valid = 1'b0;
    chk("req_valid_first", 128'(req.valid), 128'(1));
    chk("cmd_ready_busy", 128'(cmd_ready), 128'(0));
  endtask

  // Scoreboard monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 128'(1), 128'(0));
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_rdata", 128'(res_rdata), 128'(e.rdata));
        chk("res_error", 128'(res_error), 128'(e.err));
        chk("res_timeout", 128'(res_timeout), 128'(e.to));
      end
    end
  end

  initial begin
    reg_req_t exp_req;
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; res_ready = 1'b1; rsp = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("rst_res_valid", 128'(res_valid), 128'(0));
      chk("rst_res_rdata", 128'(res_rdata), 128'(0));
      chk("rst_res_flags", 128'({res_error, res_timeout}), 128'(0));
      chk("rst_req", 128'(req), 128'(0));
    end
    sel = 1'b0;
    rst_n = 1'b1;
    tick();

    // Read, zero wait: wdata/wstrb must be zeroed for reads
    issue(1'b0, 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h3, 1'b0, 1'b0);
    chk("rd_req_fields", 128'({req.write, req.wdata, req.wstrb}), 128'(0));
    rsp.ready = 1'b1; rsp.rdata = 32'h3;
    tick();
    rsp = '0;
    chk("rd_res_latency", 128'(res_valid), 128'(1));
    chk("rd_req_dropped", 128'(req.valid), 128'(0));
    tick();
    chk("rd_back_idle", 128'(res_valid), 128'(0));

    // Write with 5 wait states: request stable for 6 cycles, rdata forced to 0
    exp_req = '{addr: 32'h4, write: 1'b1, wdata: 32'h1, wstrb: 4'hF, valid: 1'b1};
    issue(1'b1, 32'h4, 32'h1, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("wr_req_stable", 128'(req), 128'(exp_req));
      if (i == 5) begin
        rsp.ready = 1'b1; rsp.rdata = 32'hAAAA_5555;
      end
      tick();
    end
    rsp = '0;
    chk("wr_res_valid", 128'(res_valid), 128'(1));
    tick();

    // Responder error
    issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick();
    rsp.ready = 1'b1; rsp.error = 1'b1; rsp.rdata = 32'hDEAD_BEEF;
    tick();
    rsp = '0;
    chk("err_res_valid", 128'(res_valid), 128'(1));
    tick();

    // Timeout on the TIMEOUT=4 instance: valid for exactly 4 cycles
    sel = 1'b1;
    tick();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    rsp.rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_valid", 128'(req.valid), 128'(1));
      chk("to_no_result", 128'(res_valid), 128'(0));
      tick();
    end
    chk("to_req_dropped", 128'(req.valid), 128'(0));
    chk("to_res_valid", 128'(res_valid), 128'(1));
    rsp = '0;
    tick();

    // Ready in the 4th valid cycle beats the timeout
    issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        rsp.ready = 1'b1; rsp.rdata = 32'h55;
      end
      tick();
    end
    rsp = '0;
    chk("bnd_res_valid", 128'(res_valid), 128'(1));
    chk("bnd_res_timeout", 128'(res_timeout), 128'(0));
    tick();

    // Back-pressure: result held, new command ignored
    sel = 1'b0;
    tick();
    res_ready = 1'b0;
    issue(1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 32'h77, 1'b0, 1'b0);
    rsp.ready = 1'b1; rsp.rdata = 32'h77;
    tick();
    rsp = '0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h99;
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_held", 128'({res_valid, res_rdata, res_error}), 128'({1'b1, 32'h77, 1'b0}));
      chk("bp_cmd_ready", 128'(cmd_ready), 128'(0));
      chk("bp_req_idle", 128'(req.valid), 128'(0));
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("bp_back_idle", 128'({cmd_ready, res_valid, req.valid}), 128'({1'b1, 1'b0, 1'b0}));

    // Reset mid-REQ: everything cleared at once, no result produced
    issue(1'b1, 32'h20, 32'hCAFE, 4'h3, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 128'(req), 128'(0));
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("mid_rst_res", 128'({res_valid, res_rdata, res_error, res_timeout}), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_quiet", 128'({req.valid, res_valid}), 128'(0));
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
